fifo_sync_param: RTL and testbench

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

---
 rtl/fifo_sync_param.sv | 184 ++++++++++++++++++
 tb/tb_fifo_sync_param.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param -- single-clock parameterised FIFO with registered read data.
//
// Parameters
//   WIDTH       data bits per entry
//   DEPTH       number of entries (power of two, 2..256)
//   AFULL_LVL   almost_full asserts when count >= AFULL_LVL
//   AEMPTY_LVL  almost_empty asserts when count <= AEMPTY_LVL
//
// Ports
//   clk           in   rising-edge clock (sole clock domain)
//   reset         in   synchronous active-high reset (highest priority)
//   clear         in   synchronous flush of pointers, count and sticky flags
//   push          in   write request, wr_data captured when accepted
//   wr_data       in   write data
//   pop           in   read request
//   rd_data       out  read data, registered, valid the cycle after an accepted pop
//   rd_valid      out  rd_data carries a freshly popped word this cycle
//   full/empty    out  count==DEPTH / count==0
//   almost_full   out  count>=AFULL_LVL
//   almost_empty  out  count<=AEMPTY_LVL
//   count         out  current occupancy
//   overflow      out  sticky: a push was dropped because the FIFO was full
//   underflow     out  sticky: a pop was rejected because the FIFO was empty
//
// Optional feature: define FIFO_SYNC_PARAM_BIST_EN to add a direct array
// access port (bist_en, bist_we, bist_addr, bist_wr_data, bist_rd_data).
// While bist_en=1 the FIFO state is frozen and rd_valid is held low.

module fifo_sync_param #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
`ifdef FIFO_SYNC_PARAM_BIST_EN
  ,
  input  logic                       bist_en,
  input  logic                       bist_we,
  input  logic [$clog2(DEPTH)-1:0]   bist_addr,
  input  logic [WIDTH-1:0]           bist_wr_data,
  output logic [WIDTH-1:0]           bist_rd_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_LVL);

  // Storage: never reset, written by push (or BIST), read into a register.
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_bist_active;
  logic             w_fifo_op;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic [CW-1:0]    w_count_next;

`ifdef FIFO_SYNC_PARAM_BIST_EN
  assign w_bist_active = bist_en;
`else
  assign w_bist_active = 1'b0;
`endif

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // Push/pop are only considered in a cycle with no reset, clear or BIST.
  assign w_fifo_op = !reset && !clear && !w_bist_active;
  assign w_pop_ok  = w_fifo_op && pop && !w_empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign w_push_ok = w_fifo_op && push && (!w_full || w_pop_ok);

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_next = r_count + 1'b1;
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Control state: pointers, count, read register and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_bist_active) begin
      // Everything frozen except rd_valid, which must not advertise stale data.
      r_rd_valid <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid <= w_pop_ok;
      r_count    <= w_count_next;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      if (push && w_full && !pop) begin
        r_overflow <= 1'b1;
      end
      if (pop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Array write port. When full with push+pop, the write lands on the slot
  // being read this same edge; the read register captures the old word.
  always_ff @(posedge clk) begin
`ifdef FIFO_SYNC_PARAM_BIST_EN
    if (bist_en) begin
      if (bist_we) begin
        r_mem[bist_addr] <= bist_wr_data;
      end
    end else
`endif
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

`ifdef FIFO_SYNC_PARAM_BIST_EN
  logic [WIDTH-1:0] r_bist_rd_data;

  always_ff @(posedge clk) begin
    r_bist_rd_data <= r_mem[bist_addr];
  end

  assign bist_rd_data = r_bist_rd_data;
`endif

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AFULL);
  assign almost_empty = (r_count <= C_AEMPTY);

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param -- directed self-checking bench for fifo_sync_param
// at its defaults (WIDTH=64, DEPTH=8, AFULL_LVL=7, AEMPTY_LVL=1).
// Inputs change 1ns after a rising edge; outputs are checked at that point.

module tb_fifo_sync_param;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic             push = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [3:0]       count;
  logic             overflow;
  logic             underflow;
`ifdef FIFO_SYNC_PARAM_BIST_EN
  logic             bist_en = 1'b0;
  logic             bist_we = 1'b0;
  logic [2:0]       bist_addr = '0;
  logic [WIDTH-1:0] bist_wr_data = '0;
  logic [WIDTH-1:0] bist_rd_data;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .push         (push),
    .wr_data      (wr_data),
    .pop          (pop),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
`ifdef FIFO_SYNC_PARAM_BIST_EN
    ,
    .bist_en      (bist_en),
    .bist_we      (bist_we),
    .bist_addr    (bist_addr),
    .bist_wr_data (bist_wr_data),
    .bist_rd_data (bist_rd_data)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- reset state ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_aempty", 64'(almost_empty), 64'd1);
    chk("rst_afull", 64'(almost_full), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_unf", 64'(underflow), 64'd0);

    // ---- fill with 1..8 ----
    for (int i = 1; i <= 8; i++) begin
      push = 1'b1;
      wr_data = 64'(i);
      tick();
      chk("fill_count", 64'(count), 64'(i));
      chk("fill_afull", 64'(almost_full), 64'(i >= 7));
      chk("fill_full", 64'(full), 64'(i == 8));
      chk("fill_aempty", 64'(almost_empty), 64'(i <= 1));
    end
    push = 1'b0;

    // ---- drain, in order ----
    for (int i = 1; i <= 8; i++) begin
      pop = 1'b1;
      tick();
      chk("drain_valid", 64'(rd_valid), 64'd1);
      chk("drain_data", rd_data, 64'(i));
      chk("drain_count", 64'(count), 64'(8 - i));
    end
    pop = 1'b0;
    tick();
    chk("idle_valid", 64'(rd_valid), 64'd0);
    chk("idle_hold", rd_data, 64'd8);
    chk("idle_empty", 64'(empty), 64'd1);

    // ---- full with simultaneous push+pop across the pointer wrap ----
    for (int i = 0; i < 8; i++) begin
      push = 1'b1;
      wr_data = 64'(16 + i);
      tick();
    end
    chk("wrap_full", 64'(full), 64'd1);
    for (int k = 0; k < 20; k++) begin
      push = 1'b1;
      pop = 1'b1;
      wr_data = 64'(24 + k);
      tick();
      chk("wrap_valid", 64'(rd_valid), 64'd1);
      chk("wrap_data", rd_data, 64'(16 + k));
      chk("wrap_count", 64'(count), 64'd8);
      chk("wrap_ovf", 64'(overflow), 64'd0);
    end
    pop = 1'b0;

    // ---- push on full without pop: dropped, overflow sticky ----
    wr_data = 64'hDEAD;
    tick();
    push = 1'b0;
    chk("ovf_count", 64'(count), 64'd8);
    chk("ovf_set", 64'(overflow), 64'd1);
    tick();
    chk("ovf_sticky", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      tick();
      chk("ovf_drain", rd_data, 64'(36 + i));
    end
    // FIFO is now empty; this pop is rejected.
    tick();
    pop = 1'b0;
    chk("unf_set", 64'(underflow), 64'd1);
    chk("unf_valid", 64'(rd_valid), 64'd0);
    chk("unf_count", 64'(count), 64'd0);

    // ---- clear drops flags and ignores a push in the same cycle ----
    clear = 1'b1;
    push = 1'b1;
    wr_data = 64'h77;
    tick();
    clear = 1'b0;
    push = 1'b0;
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_unf", 64'(underflow), 64'd0);
    chk("clr_count", 64'(count), 64'd0);

    // ---- push+pop on empty: pop rejected, push accepted ----
    push = 1'b1;
    pop = 1'b1;
    wr_data = 64'hAA;
    tick();
    push = 1'b0;
    pop = 1'b0;
    chk("pe_count", 64'(count), 64'd1);
    chk("pe_unf", 64'(underflow), 64'd1);
    chk("pe_valid", 64'(rd_valid), 64'd0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pe_data", rd_data, 64'hAA);
    chk("pe_valid2", 64'(rd_valid), 64'd1);
    chk("pe_count2", 64'(count), 64'd0);

    // ---- reset mid-stream with count=5 ----
    for (int i = 0; i < 5; i++) begin
      push = 1'b1;
      wr_data = 64'(100 + i);
      tick();
    end
    chk("mid_count5", 64'(count), 64'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push = 1'b0;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_unf", 64'(underflow), 64'd0);
    chk("mid_rst_data", rd_data, 64'd0);

    // ---- clear with count=5 ----
    for (int i = 0; i < 5; i++) begin
      push = 1'b1;
      wr_data = 64'(200 + i);
      tick();
    end
    push = 1'b0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("clr5_data", rd_data, 64'd200);
    chk("clr5_count", 64'(count), 64'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr5_count0", 64'(count), 64'd0);
    chk("clr5_empty", 64'(empty), 64'd1);
    chk("clr5_hold", rd_data, 64'd200);

    // ---- reset overrides simultaneous clear (reset also zeroes rd_data) ----
    for (int i = 0; i < 3; i++) begin
      push = 1'b1;
      wr_data = 64'(300 + i);
      tick();
    end
    push = 1'b0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("rc_pre", rd_data, 64'd300);
    reset = 1'b1;
    clear = 1'b1;
    tick();
    reset = 1'b0;
    clear = 1'b0;
    chk("rc_count", 64'(count), 64'd0);
    chk("rc_data", rd_data, 64'd0);
    // Stored entries were discarded: the next pop returns the next push.
    push = 1'b1;
    wr_data = 64'h1234;
    tick();
    push = 1'b0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("rc_after", rd_data, 64'h1234);

`ifdef FIFO_SYNC_PARAM_BIST_EN
    // ---- BIST access with FIFO frozen ----
    push = 1'b1;
    wr_data = 64'h1;
    tick();
    tick();
    push = 1'b0;
    bist_en = 1'b1;
    bist_we = 1'b1;
    bist_addr = 3'd3;
    bist_wr_data = 64'h5A5A;
    push = 1'b1;
    tick();
    bist_we = 1'b0;
    push = 1'b0;
    tick();
    chk("bist_rd", bist_rd_data, 64'h5A5A);
    chk("bist_count", 64'(count), 64'd2);
    chk("bist_valid", 64'(rd_valid), 64'd0);
    bist_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
